// File: rtl/pmem_responder.sv
// Physical-memory responder: target end of the cache-line pmem interface.
// Serves one line read/write at a time with fixed per-op latency and traffic counters.
module pmem_responder #(
    parameter int unsigned s_offset      = 5,
    parameter int unsigned s_lines       = 6,
    parameter int unsigned read_latency  = 4,
    parameter int unsigned write_latency = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           pmem_read,
    input  logic                           pmem_write,
    input  logic [31:0]                    pmem_addr,
    input  logic [8*(2**s_offset)-1:0]     pmem_wdata,
    output logic [8*(2**s_offset)-1:0]     pmem_rdata,
    output logic                           pmem_resp,
    output logic [31:0]                    read_count,
    output logic [31:0]                    write_count,
    output logic                           conflict_error
);

    localparam int unsigned s_line  = 8 * (2 ** s_offset);
    localparam int unsigned depth   = 2 ** s_lines;
    localparam int unsigned max_lat = (read_latency > write_latency) ? read_latency : write_latency;
    localparam int unsigned cnt_w   = $clog2(max_lat + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RECOVER
    } state_t;

    state_t              state;
    logic [cnt_w-1:0]    cnt;
    logic                op_write;
    logic [s_lines-1:0]  idx;
    logic [s_line-1:0]   wdata_q;
    logic [s_line-1:0]   mem [depth];

    logic [s_lines-1:0]  addr_idx;
    logic                unused_addr;

    // Only the line-index field selects a line; the rest of the address aliases.
    assign addr_idx    = pmem_addr[s_offset+s_lines-1:s_offset];
    assign unused_addr = ^{pmem_addr[31:s_offset+s_lines], pmem_addr[s_offset-1:0]};

    // pmem_resp is registered, so it is scheduled one edge before the counter hits 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            op_write       <= 1'b0;
            idx            <= '0;
            wdata_q        <= '0;
            pmem_resp      <= 1'b0;
            pmem_rdata     <= '0;
            read_count     <= '0;
            write_count    <= '0;
            conflict_error <= 1'b0;
            for (int unsigned i = 0; i < depth; i++) begin
                mem[s_lines'(i)] <= '0;
            end
        end else begin
            pmem_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (pmem_read || pmem_write) begin
                        idx      <= addr_idx;
                        wdata_q  <= pmem_wdata;
                        op_write <= pmem_write;
                        if (pmem_read && pmem_write) begin
                            conflict_error <= 1'b1;
                        end
                        if (pmem_write) begin
                            cnt <= cnt_w'(write_latency - 1);
                            if (write_latency == 1) begin
                                pmem_resp <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt_w'(read_latency - 1);
                            if (read_latency == 1) begin
                                pmem_resp  <= 1'b1;
                                pmem_rdata <= mem[addr_idx];
                            end
                        end
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == cnt_w'(1)) begin
                        pmem_resp <= 1'b1;
                        if (!op_write) begin
                            pmem_rdata <= mem[idx];
                        end
                    end
                    if (cnt == '0) begin
                        if (op_write) begin
                            mem[idx]    <= wdata_q;
                            write_count <= write_count + 32'd1;
                        end else begin
                            read_count  <= read_count + 32'd1;
                        end
                        state <= RECOVER;
                    end else begin
                        cnt <= cnt - cnt_w'(1);
                    end
                end
                RECOVER: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares on every pmem_resp.
module tb_pmem_responder;

    localparam int unsigned LINE = 256;
    localparam int          RLAT = 4;
    localparam int          WLAT = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            pmem_read, pmem_write;
    logic [31:0]     pmem_addr;
    logic [LINE-1:0] pmem_wdata, pmem_rdata;
    logic            pmem_resp;
    logic [31:0]     read_count, write_count;
    logic            conflict_error;

    logic            r1_read;
    logic [LINE-1:0] r1_rdata;
    logic            r1_resp;
    logic [31:0]     r1_read_count, r1_write_count;
    logic            r1_conflict;

    always #5 clk = ~clk;

    pmem_responder dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_addr      (pmem_addr),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp),
        .read_count     (read_count),
        .write_count    (write_count),
        .conflict_error (conflict_error)
    );

    pmem_responder #(.read_latency(1), .write_latency(2)) dut1 (
        .clk            (clk),
        .reset_n        (reset_n),
        .pmem_read      (r1_read),
        .pmem_write     (1'b0),
        .pmem_addr      (32'h0000_0040),
        .pmem_wdata     ({LINE{1'b0}}),
        .pmem_rdata     (r1_rdata),
        .pmem_resp      (r1_resp),
        .read_count     (r1_read_count),
        .write_count    (r1_write_count),
        .conflict_error (r1_conflict)
    );

    typedef struct {
        logic            is_read;
        logic [LINE-1:0] data;
        int              cyc;
    } exp_t;

    exp_t            sb[$];
    int              cyc = 0;
    int              checks = 0;
    int              errors = 0;
    logic [LINE-1:0] last_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [LINE-1:0] act, input logic [LINE-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (pmem_resp === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got pmem_resp=1 at cycle %0d want no response", cyc);
            end else begin
                e = sb.pop_front();
                check("resp_cycle", LINE'(cyc), LINE'(e.cyc));
                check(e.is_read ? "rdata" : "rdata_hold", pmem_rdata, e.data);
            end
        end
    end

    // One transaction on dut; returns in the first cycle it may accept again.
    task automatic do_op(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [LINE-1:0] wdata, input logic [LINE-1:0] rexp);
        exp_t e;
        bit   got;
        pmem_read  = rd;
        pmem_write = wr;
        pmem_addr  = addr;
        pmem_wdata = wdata;
        e.is_read  = rd & ~wr;
        e.cyc      = cyc + (wr ? WLAT : RLAT);
        if (e.is_read) last_rd = rexp;
        e.data = last_rd;
        sb.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (pmem_resp === 1'b1) got = 1'b1;
            if (i == 1) begin
                pmem_addr  = addr ^ 32'h0000_0020;
                pmem_wdata = ~wdata;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: got no pmem_resp want one for addr %h", addr);
        end
        @(posedge clk);
        #1;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no end of test want $finish");
        $fatal(1);
    end

    initial begin : stim
        logic [LINE-1:0] pat_a5, pat_p, pat_q, pat_r, pat_w;
        pat_a5 = {32{8'hA5}};
        pat_p  = {8{32'hDEAD_BEEF}};
        pat_q  = {16{16'h1234}};
        pat_r  = {4{64'h0123_4567_89AB_CDEF}};
        pat_w  = {32{8'h3C}};

        reset_n = 1'b0; pmem_read = 1'b0; pmem_write = 1'b0;
        pmem_addr = '0; pmem_wdata = '0; r1_read = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_resp",     LINE'(pmem_resp),      LINE'(1'b0));
        check("reset_rdata",    pmem_rdata,            '0);
        check("reset_rcount",   LINE'(read_count),     '0);
        check("reset_wcount",   LINE'(write_count),    '0);
        check("reset_conflict", LINE'(conflict_error), '0);
        reset_n = 1'b1;

        do_op(1'b1, 1'b0, 32'h0000_0040, '0, '0);
        check("rcount_after_first_read", LINE'(read_count), LINE'(32'd1));

        do_op(1'b0, 1'b1, 32'h0000_0020, pat_a5, '0);
        do_op(1'b1, 1'b0, 32'h0000_0020, '0, pat_a5);
        check("wcount_after_write", LINE'(write_count), LINE'(32'd1));
        check("rcount_after_raw",   LINE'(read_count),  LINE'(32'd2));

        do_op(1'b0, 1'b1, 32'h0000_0800, pat_p, '0);
        do_op(1'b1, 1'b0, 32'h0000_0000, '0, pat_p);

        do_op(1'b1, 1'b1, 32'h0000_0060, pat_q, '0);
        check("conflict_set",      LINE'(conflict_error), LINE'(1'b1));
        check("conflict_wcount",   LINE'(write_count),    LINE'(32'd3));
        check("conflict_rcount",   LINE'(read_count),     LINE'(32'd3));
        do_op(1'b1, 1'b0, 32'h0000_0060, '0, pat_q);
        do_op(1'b0, 1'b1, 32'h0000_0040, pat_w, '0);
        check("conflict_sticky",   LINE'(conflict_error), LINE'(1'b1));
        do_op(1'b1, 1'b0, 32'h0000_0040, '0, pat_w);

        pmem_write = 1'b1; pmem_addr = 32'h0000_0080; pmem_wdata = pat_r;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1; pmem_write = 1'b0;
        last_rd = '0;
        repeat (6) @(posedge clk);
        #1;
        check("midreset_wcount",   LINE'(write_count),    '0);
        check("midreset_conflict", LINE'(conflict_error), '0);
        do_op(1'b1, 1'b0, 32'h0000_0080, '0, '0);
        do_op(1'b1, 1'b0, 32'h0000_0020, '0, '0);

        r1_read = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("lat1_resp_%0d", i), LINE'(r1_resp), LINE'((i % 3) == 1));
        end
        @(posedge clk); #1;
        r1_read = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("lat1_rcount", LINE'(r1_read_count), LINE'(32'd4));

        repeat (5) @(posedge clk);
        #1;
        check("sb_drained", LINE'(sb.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
